pc_gen: RTL and testbench
=========================

# pc_gen

Program-counter generation unit for the RV32I fetch stage: it holds the architectural fetch PC and selects the next PC from sequential (PC+4), predicted-taken (branch target buffer hit) or redirect (execute-stage correction / trap) sources. It adds stall handling, a parametrised direct-mapped branch target buffer (BTB) trained from execute, and redirect-target misalignment flagging to the pure combinational next-PC selection of the single-cycle datapath. It sits between the instruction-memory address port and the execute/branch-resolution logic.

## Interface
- XLEN, 32: datapath/address width.
- RESET_VECTOR, 32'h0000_0000: PC value loaded on reset; must be 4-byte aligned.
- BTB_ENTRIES, 16: BTB depth; power of two, ≥2. IDX_W = log2(BTB_ENTRIES).

- clk  in  1  single clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hold PC (fetch back-pressure / hazard).
- redirect_valid  in  1  execute-stage correction or trap; overrides everything.
- redirect_target  in  XLEN  new PC when redirect_valid.
- upd_valid  in  1  BTB training strobe from execute (resolved branch/jump).
- upd_pc  in  XLEN  PC of the resolved control instruction.
- upd_target  in  XLEN  resolved target.
- upd_taken  in  1  resolved direction.
- pc_out  out  XLEN  current fetch PC (registered).
- pc_plus4  out  XLEN  pc_out + 4 (combinational, link value).
- pred_taken  out  1  BTB hit on pc_out (combinational).
- pred_target  out  XLEN  BTB target for pc_out; 0 when no hit.
- misaligned  out  1  registered; high for one cycle after a redirect whose target[1:0] ≠ 0.

## Operation
- Reset (rst=1 at edge): pc_out ← RESET_VECTOR, all BTB valid bits ← 0, misaligned ← 0. Reset wins over every other input, including redirect_valid and upd_valid. After reset: pred_taken=0, pred_target=0, pc_plus4 = RESET_VECTOR+4.
- Next-PC priority (highest first):
  - redirect_valid: redirect_target with bits [1:0] forced to 0. Applies even when stall=1.
  - stall: pc_out holds.
  - pred_taken: pred_target.
  - else: pc_out + 4.
- All additions are modulo 2^XLEN; 32'hFFFF_FFFC + 4 wraps to 0 with no flag.
- BTB entry: valid, tag = pc[XLEN-1:IDX_W+2], target[XLEN-1:2]. Index = pc[IDX_W+1:2]. Lookup on pc_out is combinational. Hit = valid && tag match.
- Training on upd_valid:
  - upd_taken=1: write valid=1, tag and target at the upd_pc index. Replace unconditionally.
  - upd_taken=0: clear valid only if that entry's tag matches upd_pc. Otherwise no change.
  - upd_valid is honoured regardless of stall or redirect_valid.
- misaligned ← redirect_valid && (redirect_target[1:0] ≠ 0); else 0. The trap logic consumes it.

## Timing
- pc_out: one-cycle latency from any select input to the new value (registered at edge).
- pred_taken, pred_target and pc_plus4 follow pc_out in the same cycle (combinational).
- BTB write takes effect at the edge. A lookup in the same cycle as an update to the same index sees the old contents; the next cycle sees the new contents.
- Simultaneous redirect_valid and stall: redirect wins, PC updates, stall is ignored that cycle.
- Simultaneous redirect and upd to the entry hit by the current pc_out: redirect is still chosen; the BTB update still commits.
- Reset asserted mid-sequence: PC and BTB are cleared at the next edge; no pending update survives.
- Throughput: one new PC per cycle when not stalled.

## Test plan
- Reset then 4 free-running cycles, no updates -> pc_out = 0, 4, 8, 12, 16; pred_taken=0 throughout.
- Train: upd_valid=1, upd_pc=0x10, upd_target=0x40, upd_taken=1 while pc_out=0x08 -> pc_out=0x0C, then 0x10 with pred_taken=1, pred_target=0x40, then 0x40.
- Untrain: upd_pc=0x10 upd_taken=0 -> next visit to 0x10 predicts not-taken, goes to 0x14. Repeat with an aliased upd_pc = 0x10 + 4·BTB_ENTRIES -> entry at 0x10 remains valid.
- stall=1 for 3 cycles at pc=0x20, redirect_valid=1 target=0x102 on the 2nd stalled cycle -> pc_out = 0x100 next cycle, misaligned=1 for exactly that cycle.
- pc_out=0xFFFF_FFFC, no hit -> next pc_out=0x0000_0000.
- Assert rst during a redirect with a trained BTB -> pc_out=RESET_VECTOR, pred_taken=0 at formerly trained PCs.

Source files
------------

// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - RV32I fetch program-counter generator with a direct-mapped branch target buffer.
module pc_gen #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              BTB_ENTRIES  = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic [XLEN-1:0] upd_target,
    input  logic            upd_taken,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] pc_plus4,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    output logic            misaligned
);
    localparam int IDX_W = $clog2(BTB_ENTRIES);
    localparam int TAG_W = XLEN - IDX_W - 2;

    logic [XLEN-1:0]        pc_q, pc_d;
    logic                   misaligned_q, misaligned_d;
    logic [BTB_ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]       tag_q [BTB_ENTRIES];
    logic [XLEN-3:0]        tgt_q [BTB_ENTRIES];

    logic [IDX_W-1:0]       look_idx, upd_idx;
    logic [TAG_W-1:0]       look_tag, upd_tag;
    logic                   hit;
    logic                   unused_bits;

    assign look_idx = pc_q[IDX_W+1:2];
    assign look_tag = pc_q[XLEN-1:IDX_W+2];
    assign upd_idx  = upd_pc[IDX_W+1:2];
    assign upd_tag  = upd_pc[XLEN-1:IDX_W+2];

    assign hit         = valid_q[look_idx] && (tag_q[look_idx] == look_tag);
    assign pred_taken  = hit;
    assign pred_target = hit ? {tgt_q[look_idx], 2'b00} : '0;
    assign pc_out      = pc_q;
    assign pc_plus4    = pc_q + XLEN'(4);
    assign misaligned  = misaligned_q;

    // Low address bits of training inputs carry no information for word-aligned fetch.
    assign unused_bits = ^{upd_pc[1:0], upd_target[1:0]};

    always_comb begin
        pc_d         = pc_q + XLEN'(4);
        misaligned_d = 1'b0;
        if (redirect_valid) begin
            pc_d         = {redirect_target[XLEN-1:2], 2'b00};
            misaligned_d = (redirect_target[1:0] != 2'b00);
        end else if (stall) begin
            pc_d = pc_q;
        end else if (hit) begin
            pc_d = pred_target;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q         <= RESET_VECTOR;
            misaligned_q <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            misaligned_q <= misaligned_d;
        end
    end

    // Not-taken training only evicts the entry if it belongs to this branch, not an alias.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (upd_valid) begin
            if (upd_taken) begin
                valid_q[upd_idx] <= 1'b1;
                tag_q[upd_idx]   <= upd_tag;
                tgt_q[upd_idx]   <= upd_target[XLEN-1:2];
            end else if (tag_q[upd_idx] == upd_tag) begin
                valid_q[upd_idx] <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_pc_gen.sv
// tb/tb_pc_gen.sv - directed self-checking bench for pc_gen.
module tb_pc_gen;
    logic        clk = 1'b0;
    logic        rst, stall, redirect_valid, upd_valid, upd_taken;
    logic [31:0] redirect_target, upd_pc, upd_target;
    logic [31:0] pc_out, pc_plus4, pred_target;
    logic        pred_taken, misaligned;

    int n_pass = 0;
    int n_total = 0;

    pc_gen #(.XLEN(32), .RESET_VECTOR(32'h0), .BTB_ENTRIES(16)) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target), .upd_taken(upd_taken),
        .pc_out(pc_out), .pc_plus4(pc_plus4), .pred_taken(pred_taken),
        .pred_target(pred_target), .misaligned(misaligned)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 0; stall = 0; redirect_valid = 0; redirect_target = '0;
        upd_valid = 0; upd_pc = '0; upd_target = '0; upd_taken = 0;
    endtask

    task automatic redirect_to(input logic [31:0] t);
        redirect_valid = 1; redirect_target = t;
        tick();
        redirect_valid = 0;
    endtask

    initial begin
        idle();
        rst = 1;
        tick(); tick();
        rst = 0;
        check("rst_pc", pc_out, 32'h0);
        check("rst_pred", {31'b0, pred_taken}, 32'h0);
        check("rst_ptgt", pred_target, 32'h0);
        check("rst_plus4", pc_plus4, 32'h4);
        check("rst_mis", {31'b0, misaligned}, 32'h0);

        tick(); check("free_4", pc_out, 32'h4);
        tick(); check("free_8", pc_out, 32'h8);
        check("free_nopred", {31'b0, pred_taken}, 32'h0);

        // Train 0x10 -> 0x40 while fetching 0x08
        upd_valid = 1; upd_pc = 32'h10; upd_target = 32'h40; upd_taken = 1;
        tick(); upd_valid = 0;
        check("trn_pc_c", pc_out, 32'h0C);
        check("trn_nopred_c", {31'b0, pred_taken}, 32'h0);
        tick();
        check("trn_pc_10", pc_out, 32'h10);
        check("trn_pred", {31'b0, pred_taken}, 32'h1);
        check("trn_ptgt", pred_target, 32'h40);
        tick();
        check("trn_pc_40", pc_out, 32'h40);

        // Aliased not-taken (0x10 + 64) must not evict the 0x10 entry
        upd_valid = 1; upd_pc = 32'h50; upd_taken = 0;
        tick(); upd_valid = 0;
        check("alias_pc", pc_out, 32'h44);
        redirect_to(32'h10);
        check("alias_pc10", pc_out, 32'h10);
        check("alias_kept", {31'b0, pred_taken}, 32'h1);

        // Untrain 0x10 while stalled on it; lookup that cycle still sees old entry
        stall = 1; upd_valid = 1; upd_pc = 32'h10; upd_taken = 0;
        tick(); upd_valid = 0;
        check("untrn_hold", pc_out, 32'h10);
        check("untrn_pred", {31'b0, pred_taken}, 32'h0);
        stall = 0;
        tick();
        check("untrn_seq", pc_out, 32'h14);

        // Stall 3 cycles at 0x20 with misaligned redirect on the 2nd
        redirect_to(32'h20);
        stall = 1;
        tick(); check("stall1", pc_out, 32'h20);
        check("stall1_mis", {31'b0, misaligned}, 32'h0);
        redirect_valid = 1; redirect_target = 32'h102;
        tick(); redirect_valid = 0;
        check("stall_redir", pc_out, 32'h100);
        check("mis_set", {31'b0, misaligned}, 32'h1);
        tick();
        check("stall3", pc_out, 32'h100);
        check("mis_clr", {31'b0, misaligned}, 32'h0);
        stall = 0;

        // Wrap-around
        redirect_to(32'hFFFF_FFFC);
        check("wrap_pc", pc_out, 32'hFFFF_FFFC);
        check("wrap_plus4", pc_plus4, 32'h0);
        check("wrap_mis", {31'b0, misaligned}, 32'h0);
        tick();
        check("wrap_next", pc_out, 32'h0);

        // Retrain, then redirect while updating another entry
        upd_valid = 1; upd_pc = 32'h10; upd_target = 32'h40; upd_taken = 1;
        tick(); upd_valid = 0;
        redirect_to(32'h10);
        check("re_pred", {31'b0, pred_taken}, 32'h1);
        upd_valid = 1; upd_pc = 32'h30; upd_target = 32'h80; upd_taken = 1;
        redirect_to(32'h200);
        upd_valid = 0;
        check("redir_over_pred", pc_out, 32'h200);
        redirect_to(32'h30);
        check("upd_commit", {31'b0, pred_taken}, 32'h1);
        check("upd_ptgt", pred_target, 32'h80);

        // Reset during redirect + pending update
        rst = 1; redirect_valid = 1; redirect_target = 32'h81;
        upd_valid = 1; upd_pc = 32'h20; upd_target = 32'hC0; upd_taken = 1;
        tick();
        idle();
        check("mrst_pc", pc_out, 32'h0);
        check("mrst_mis", {31'b0, misaligned}, 32'h0);
        redirect_to(32'h10);
        check("mrst_pred10", {31'b0, pred_taken}, 32'h0);
        redirect_to(32'h30);
        check("mrst_pred30", {31'b0, pred_taken}, 32'h0);
        redirect_to(32'h20);
        check("mrst_pred20", {31'b0, pred_taken}, 32'h0);
        tick();
        check("mrst_seq", pc_out, 32'h24);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
